// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and sizing helpers for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam int STALL_W = 16;

  // Width of an owner index; never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin selector starting after last_owner
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int OW = owner_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last_owner,
  output logic            found,
  output logic [OW-1:0]   owner
);

  int best;

  // Distance of producer i from the slot right after last_owner, wrapping.
  function automatic int rr_dist(input int i, input int lo);
    return (i + NREQ - 1 - lo) % NREQ;
  endfunction

  // Choose the requesting producer closest (in rotation order) to last_owner+1.
  always_comb begin
    found = 1'b0;
    owner = '0;
    best  = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (rr_dist(i, int'(last_owner)) < best)) begin
        best  = rr_dist(i, int'(last_owner));
        owner = OW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing the async FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATASIZE  = 8,
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          ack,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DATASIZE-1:0]      wdata,
  output logic [NREQ-1:0]          grant,
  output logic [STALL_W-1:0]       stall_cnt
);

  localparam int OW = owner_w(NREQ);
  localparam int BW = 8;

  arb_state_t          state, state_next;
  logic [OW-1:0]       owner, owner_next;
  logic [OW-1:0]       last_owner, last_owner_next;
  logic [BW-1:0]       beat_cnt, beat_cnt_next;
  logic [STALL_W-1:0]  stall_next;
  logic                pick_found;
  logic [OW-1:0]       pick_owner;
  logic [NREQ-1:0]     owner_onehot;
  logic                owner_req;
  logic [DATASIZE-1:0] owner_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .found      (pick_found),
    .owner      (pick_owner)
  );

  // Decode the registered owner into its one-hot, request bit and data slice.
  always_comb begin
    owner_onehot = '0;
    owner_req    = 1'b0;
    owner_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == OW'(i)) begin
        owner_onehot[i] = 1'b1;
        owner_req       = req[i];
        owner_data      = req_data[i*DATASIZE +: DATASIZE];
      end
    end
  end

  // Next-state and port outputs; a dropped request outranks burst completion.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    beat_cnt_next   = beat_cnt;
    stall_next      = stall_cnt;
    grant           = '0;
    winc            = 1'b0;
    ack             = '0;
    wdata           = '0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          owner_next    = pick_owner;
          beat_cnt_next = '0;
          state_next    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        grant = owner_onehot;
        wdata = owner_data;
        // Reset gates the write so a burst cut by reset never half-commits.
        winc  = owner_req & ~wfull & ~wrst;
        ack   = {NREQ{winc}} & owner_onehot;
        if (!owner_req) begin
          state_next      = ARB_IDLE;
          last_owner_next = owner;
        end else if (wfull) begin
          if (stall_cnt != '1) stall_next = stall_cnt + STALL_W'(1);
        end else if (winc) begin
          beat_cnt_next = beat_cnt + BW'(1);
          if (beat_cnt == BW'(BURST_LEN - 1)) begin
            state_next      = ARB_IDLE;
            last_owner_next = owner;
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // State, owner bookkeeping and counters; last_owner resets so producer 0 wins first.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      last_owner <= OW'(NREQ - 1);
      beat_cnt   <= '0;
      stall_cnt  <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      beat_cnt   <= beat_cnt_next;
      stall_cnt  <= stall_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for the FIFO write arbiter
module tb_fifo_wr_arbiter;

  localparam int DS   = 8;
  localparam int NREQ = 4;
  localparam int BL   = 4;

  logic              wclk;
  logic              wrst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DS-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              wfull;
  logic              winc;
  logic [DS-1:0]     wdata;
  logic [NREQ-1:0]   grant;
  logic [15:0]       stall_cnt;

  fifo_wr_arbiter #(.DATASIZE(DS), .NREQ(NREQ), .BURST_LEN(BL)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
    .stall_cnt (stall_cnt)
  );

  typedef struct packed {
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [15:0] stall;
  } cyc_t;

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] data;
  } wr_t;

  cyc_t cq[$];
  wr_t  wq[$];
  logic [7:0] pq [NREQ][$];

  int total = 0;
  int bad   = 0;

  bit m_busy;
  int m_owner, m_beats, m_last, m_stall;

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the reference model decides what this cycle must show.
  task automatic step(input logic [3:0] en, input logic full, input logic rst);
    logic [3:0]  r;
    logic [31:0] rd;
    cyc_t        c;
    bit          hit;
    int          p;
    @(negedge wclk);
    for (int i = 0; i < NREQ; i++) begin
      r[i] = en[i] && (pq[i].size() > 0);
      rd[i*DS +: DS] = r[i] ? pq[i][0] : 8'($urandom);
    end
    wrst     = rst;
    wfull    = full;
    req      = r;
    req_data = rd;
    c.grant = m_busy ? 4'(1 << m_owner) : 4'h0;
    c.ack   = 4'h0;
    c.stall = 16'(m_stall);
    if (rst) begin
      m_busy  = 0;
      m_last  = NREQ - 1;
      m_stall = 0;
    end else if (!m_busy) begin
      hit = 0;
      for (int k = 1; k <= NREQ; k++) begin
        p = (m_last + k) % NREQ;
        if (!hit && r[p]) begin
          hit = 1;
          m_owner = p;
        end
      end
      if (hit) begin
        m_busy  = 1;
        m_beats = 0;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0;
      m_last = m_owner;
    end else if (full) begin
      if (m_stall < 65535) m_stall++;
    end else begin
      c.ack = 4'(1 << m_owner);
      wq.push_back('{grant: 4'(1 << m_owner), data: pq[m_owner][0]});
      void'(pq[m_owner].pop_front());
      m_beats++;
      if (m_beats == BL) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end
    cq.push_back(c);
  endtask

  task automatic push(input int i, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) pq[i].push_back(base + 8'(k));
  endtask

  task automatic run(input int n, input logic [3:0] en, input logic full);
    for (int k = 0; k < n; k++) step(en, full, 1'b0);
  endtask

  // Monitor: checks every modelled cycle and every write the DUT actually issues.
  initial begin
    cyc_t c;
    wr_t  w;
    forever begin
      @(negedge wclk);
      #2;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("grant", 32'(grant), 32'(c.grant));
        chk("ack", 32'(ack), 32'(c.ack));
        chk("stall_cnt", 32'(stall_cnt), 32'(c.stall));
        chk("winc", 32'(winc), 32'(|c.ack));
      end
      if (winc === 1'b1) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=winc=1 data=%0h required=no write", wdata);
        end else begin
          w = wq.pop_front();
          chk("wdata", 32'(wdata), 32'(w.data));
          chk("write_owner", 32'(grant), 32'(w.grant));
        end
      end
    end
  end

  initial begin
    logic [3:0] en;
    wrst     = 1'b1;
    req      = '0;
    req_data = '0;
    wfull    = 1'b0;
    m_busy   = 0;
    m_owner  = 0;
    m_beats  = 0;
    m_last   = NREQ - 1;
    m_stall  = 0;
    @(posedge wclk);
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_winc", 32'(winc), 32'h0);
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_stall", 32'(stall_cnt), 32'h0);
    chk("reset_wdata", 32'(wdata), 32'h0);

    // single producer, six beats across two bursts
    push(0, 6, 8'h10);
    run(10, 4'b0001, 1'b0);

    // all four producers with two beats each
    for (int i = 0; i < NREQ; i++) push(i, 2, 8'(8'h20 + 8'(i * 16)));
    run(20, 4'b1111, 1'b0);

    // owner 2 stalled by wfull mid-burst for five cycles
    push(2, 4, 8'h60);
    run(2, 4'b0100, 1'b0);
    run(5, 4'b0100, 1'b1);
    @(posedge wclk);
    #1;
    chk("stall_after_hold", 32'(stall_cnt), 32'd5);
    run(6, 4'b0100, 1'b0);

    // fairness: after owner 1, owner 3 goes ahead of owner 1
    push(1, 1, 8'h70);
    run(4, 4'b0010, 1'b0);
    push(1, 2, 8'h80);
    push(3, 2, 8'h90);
    run(10, 4'b1010, 1'b0);

    // reset after beat 2 of owner 0
    push(0, 4, 8'hA0);
    push(3, 2, 8'hB0);
    run(3, 4'b0001, 1'b0);
    step(4'b0001, 1'b0, 1'b1);
    run(12, 4'b1001, 1'b0);

    // owner 0 drops its request after one beat
    push(0, 4, 8'hC0);
    push(2, 2, 8'hD0);
    run(2, 4'b0101, 1'b0);
    run(6, 4'b0100, 1'b0);
    run(8, 4'b0001, 1'b0);

    // randomized traffic with stalls, drops and occasional reset
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pq[i].size() < 3 && $urandom_range(0, 3) == 0) pq[i].push_back(8'($urandom));
        en[i] = ($urandom_range(0, 9) < 9);
      end
      step(en, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end
    run(120, 4'b1111, 1'b0);
    run(3, 4'b0000, 1'b0);
    @(negedge wclk);
    #3;
    chk("writes_outstanding", 32'(wq.size()), 32'd0);
    chk("cycles_outstanding", 32'(cq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
